// File: rtl/missile_pkg.sv
// rtl/missile_pkg.sv - shared screen geometry, widths, colours and line-draw states
package missile_pkg;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;

  localparam int DEF_XW = 9;
  localparam int DEF_YW = 8;
  localparam int DEF_CW = 3;

  typedef logic [2:0] color_t;

  localparam color_t BLACK = 3'b000;
  localparam color_t WHITE = 3'b111;
  localparam color_t TRAIL = 3'b100;

  typedef enum logic [1:0] {
    LD_IDLE  = 2'd0,
    LD_SETUP = 2'd1,
    LD_DRAW  = 2'd2,
    LD_DONE  = 2'd3
  } ld_state_e;

endpackage

// File: rtl/missile_line_draw.sv
// rtl/missile_line_draw.sv - Bresenham missile-trail rasteriser into the VGA pixel-write port
// Define MISSILE_LINE_CLIP_EN to suppress plot for off-screen pixels while still stepping them.
module missile_line_draw
  import missile_pkg::*;
#(
  parameter int XW = DEF_XW,
  parameter int YW = DEF_YW,
  parameter int CW = DEF_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [XW-1:0] x0,
  input  logic [YW-1:0] y0,
  input  logic [XW-1:0] x1,
  input  logic [YW-1:0] y1,
  input  logic [CW-1:0] color_in,
  input  logic          pix_ready,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic [CW-1:0] pix_color,
  output logic          plot,
  output logic          busy,
  output logic          done
);

  localparam int DW = XW + 2;

  localparam logic [1:0] IDLE  = 2'(LD_IDLE);
  localparam logic [1:0] SETUP = 2'(LD_SETUP);
  localparam logic [1:0] DRAW  = 2'(LD_DRAW);
  localparam logic [1:0] DONE  = 2'(LD_DONE);

  logic [1:0]    state;
  logic [XW-1:0] x0_q, x1_q, cx;
  logic [YW-1:0] y0_q, y1_q, cy;
  logic [CW-1:0] col_q;
  logic          sx_neg, sy_neg;

  logic signed [DW-1:0] dx, dy, err;
  logic signed [DW-1:0] x_diff, y_diff, dx_abs, dy_abs, err_next;
  logic signed [DW:0]   e2, dx_ext, dy_ext;
  logic                 step_x, step_y, at_end, off, advance;

  assign x_diff = $signed(DW'(x1_q)) - $signed(DW'(x0_q));
  assign y_diff = $signed(DW'(y1_q)) - $signed(DW'(y0_q));
  assign dx_abs = x_diff[DW-1] ? -x_diff : x_diff;
  assign dy_abs = y_diff[DW-1] ? -y_diff : y_diff;

  // e2 = 2*err, compared against sign-extended deltas at the wider width
  assign e2     = {err, 1'b0};
  assign dx_ext = {dx[DW-1], dx};
  assign dy_ext = {dy[DW-1], dy};
  assign step_x = (e2 >= dy_ext);
  assign step_y = (e2 <= dx_ext);
  assign err_next = err + (step_x ? dy : '0) + (step_y ? dx : '0);

  assign at_end = (cx == x1_q) && (cy == y1_q);

`ifdef MISSILE_LINE_CLIP_EN
  assign off = (int'(cx) >= SCREEN_W) || (int'(cy) >= SCREEN_H);
`else
  assign off = 1'b0;
`endif

  // Off-screen pixels never reach the adapter, so they must not wait on it either
  assign advance = (state == DRAW) && (pix_ready || off);

  assign plot      = (state == DRAW) && !off;
  assign pix_x     = cx;
  assign pix_y     = cy;
  assign pix_color = col_q;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      x0_q   <= '0;
      x1_q   <= '0;
      y0_q   <= '0;
      y1_q   <= '0;
      col_q  <= '0;
      cx     <= '0;
      cy     <= '0;
      dx     <= '0;
      dy     <= '0;
      err    <= '0;
      sx_neg <= 1'b0;
      sy_neg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            x0_q  <= x0;
            y0_q  <= y0;
            x1_q  <= x1;
            y1_q  <= y1;
            col_q <= color_in;
            state <= SETUP;
          end
        end
        SETUP: begin
          dx     <= dx_abs;
          dy     <= -dy_abs;
          err    <= dx_abs - dy_abs;
          sx_neg <= !(x0_q < x1_q);
          sy_neg <= !(y0_q < y1_q);
          cx     <= x0_q;
          cy     <= y0_q;
          state  <= DRAW;
        end
        DRAW: begin
          if (advance) begin
            if (at_end) begin
              state <= DONE;
            end else begin
              err <= err_next;
              if (step_x) cx <= cx + (sx_neg ? {XW{1'b1}} : XW'(1));
              if (step_y) cy <= cy + (sy_neg ? {YW{1'b1}} : YW'(1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_missile_line_draw.sv
// tb/tb_missile_line_draw.sv - scoreboard bench for missile_line_draw
module tb_missile_line_draw;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [8:0] x0, x1;
  logic [7:0] y0, y1;
  logic [2:0] color_in;
  logic       pix_ready;
  logic [8:0] pix_x;
  logic [7:0] pix_y;
  logic [2:0] pix_color;
  logic       plot, busy, done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_acc = -10;
  int busy_cycles = 0;
  int done_count = 0;
  logic [19:0] sb[$];

  missile_line_draw dut (
    .clk(clk), .rst(rst), .start(start),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .color_in(color_in),
    .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
    .plot(plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_px(input int x, input int y, input logic [2:0] c);
    sb.push_back({9'(x), 8'(y), c});
  endtask

  always @(negedge clk) begin
    logic [19:0] exp_px;
    cyc++;
    if (busy) busy_cycles++;
    if (done) done_count++;
    if (plot && pix_ready) begin
      last_acc = cyc;
      if (sb.size() == 0) begin
        check("unexpected_pixel", {pix_x, pix_y, pix_color}, 32'hFFFFF);
      end else begin
        exp_px = sb.pop_front();
        check("pixel", {pix_x, pix_y, pix_color}, exp_px);
      end
    end
  end

  task automatic start_line(input int a, input int b, input int c, input int d, input logic [2:0] col);
    @(posedge clk); #1;
    x0 = 9'(a); y0 = 8'(b); x1 = 9'(c); y1 = 8'(d); color_in = col;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    int dc;
    dc = done_count;
    for (n = 0; n < 200; n++) begin
      @(negedge clk); #1;
      if (done) break;
    end
    if (n == 200) begin
      check("done_timeout", 0, 1);
    end else begin
      check("done_after_last_pixel", cyc - last_acc, 1);
      check("scoreboard_drained", sb.size(), 0);
      check("done_busy", busy, 1);
      check("done_plot", plot, 0);
      check("done_count", done_count - dc, 1);
      @(negedge clk); #1;
      check("done_one_cycle", done, 0);
      check("idle_after_done", busy, 0);
    end
    sb.delete();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pix_ready = 1'b1;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0; color_in = '0;
    #2;
    check("reset_outputs", {pix_x, pix_y, pix_color, plot, busy, done}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // horizontal line, latency and busy length
    for (int i = 0; i <= 4; i++) push_px(i, 210, 3'b100);
    busy_cycles = 0;
    start_line(0, 210, 4, 210, 3'b100);
    check("setup_busy", busy, 1);
    check("setup_no_plot", plot, 0);
    @(posedge clk); #1;
    check("first_plot_latency", plot, 1);
    wait_done();
    check("busy_cycles_h", busy_cycles, 7);

    // steep line
    push_px(10, 10, 3'b111); push_px(10, 11, 3'b111); push_px(11, 12, 3'b111);
    push_px(11, 13, 3'b111); push_px(12, 14, 3'b111); push_px(12, 15, 3'b111);
    start_line(10, 10, 12, 15, 3'b111);
    wait_done();

    // reverse diagonal
    for (int i = 13; i >= 10; i--) push_px(i, i, 3'b010);
    start_line(13, 13, 10, 10, 3'b010);
    wait_done();

    // degenerate single point
    push_px(5, 5, 3'b001);
    start_line(5, 5, 5, 5, 3'b001);
    wait_done();

    // backpressure at the second pixel
    for (int i = 0; i <= 3; i++) push_px(i, 0, 3'b110);
    start_line(0, 0, 3, 0, 3'b110);
    @(posedge clk); #1;
    @(posedge clk); #1;
    pix_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("stall_hold_x", pix_x, 1);
      check("stall_plot", plot, 1);
    end
    @(posedge clk); #1;
    pix_ready = 1'b1;
    check("stall_release_x", pix_x, 1);
    wait_done();

    // start while busy is ignored
    for (int i = 0; i <= 7; i++) push_px(i, 100, 3'b011);
    start_line(0, 100, 7, 100, 3'b011);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("third_pixel_x", pix_x, 2);
    x0 = 9'd50; y0 = 8'd60; x1 = 9'd70; y1 = 8'd80; color_in = 3'b101;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();

    // asynchronous reset mid-line
    for (int i = 0; i <= 9; i++) push_px(i, 50, 3'b111);
    start_line(0, 50, 9, 50, 3'b111);
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_reset_outputs", {pix_x, pix_y, pix_color, plot, busy, done}, 0);
    sb.delete();
    begin
      int dc;
      dc = done_count;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("no_done_after_reset", done_count - dc, 0);
    end
    push_px(20, 30, 3'b100); push_px(21, 31, 3'b100);
    push_px(22, 31, 3'b100); push_px(23, 32, 3'b100);
    start_line(20, 30, 23, 32, 3'b100);
    wait_done();

    // right-edge line: clipped or plotted depending on build
`ifdef MISSILE_LINE_CLIP_EN
    push_px(318, 0, 3'b111); push_px(319, 0, 3'b111);
`else
    for (int i = 318; i <= 322; i++) push_px(i, 0, 3'b111);
`endif
    start_line(318, 0, 322, 0, 3'b111);
    wait_done();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
